codificador_priori: RTL and testbench
=====================================

CODIFICADOR_PRIORI -- requirements
Module: codificador_priori

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1, giving the number of consecutive identical clock samples needed before a key code is reported valid (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port teclado, input, 10 bits: keypad lines, bit i high = digit key i pressed (i = 0..9).
REQ-005 SHALL have port enablen, input, 1 bit: active-low enable; 0 = encoder active, 1 = encoder disabled.
REQ-006 SHALL have port BCD, output, 4 bits: registered BCD code of the highest-priority pressed key.
REQ-007 SHALL have port dado_valido, output, 1 bit: registered flag, high while BCD holds a valid, stable key code.
REQ-008 SHALL have port tecla_nova, output, 1 bit: registered one-cycle pulse marking a newly accepted key code.

Function
REQ-009 SHALL compute a combinational raw code as the index of the highest set bit of teclado; bit 9 has highest priority and bit 0 lowest (10'b1000001001 -> 9).
REQ-010 SHALL treat the raw code as present only when enablen = 0 and teclado is nonzero; otherwise it is absent.
REQ-011 SHALL keep a stability counter: it increments, saturating at STABLE_CYCLES, while the present raw code equals the previous cycle's present raw code; any change of code or absence reloads it to 1 if present, or 0 if absent.
REQ-012 SHALL, on the rising edge where the counter reaches STABLE_CYCLES with code present, register BCD = raw code and dado_valido = 1.
REQ-013 With STABLE_CYCLES = 1, SHALL give exactly one clock of latency from teclado/enablen to BCD/dado_valido.
REQ-014 SHALL, on any edge where the code is absent (enablen = 1 or teclado = 0), register BCD = 4'b0000 and dado_valido = 0.
REQ-015 SHALL, while a code is present but not yet stable, hold dado_valido = 0 and BCD = 4'b0000.
REQ-016 SHALL assert tecla_nova for exactly one cycle, on the same edge where dado_valido rises or where BCD changes value while dado_valido stays 1; otherwise 0.
REQ-017 SHALL never output a BCD value above 9.
REQ-018 SHALL give enablen = 1 precedence over any teclado pattern; the encoder is disabled even with multiple keys pressed.
REQ-019 SHALL, when several keys are pressed at once, depend only on the highest pressed index; lower keys pressed or released do not reset the stability counter.

Reset
REQ-020 SHALL, while rstn = 0, immediately drive BCD = 4'b0000, dado_valido = 0 and tecla_nova = 0, and clear the stability counter and the stored previous code, independent of clk.
REQ-021 SHALL resume normal operation on the first rising clk edge after rstn returns to 1; a key held through reset needs a full STABLE_CYCLES samples before it is reported.
REQ-022 SHALL handle reset asserted mid-sequence with no residual state.

Verification
REQ-023 Walk one-hot: STABLE_CYCLES = 1, enablen = 0, teclado 10'b1000000000 down to 10'b0000000001 one per cycle -> BCD 9,8,...,0 one cycle later, dado_valido = 1 and tecla_nova = 1 each cycle.
REQ-024 Disabled: same walk with enablen = 1 -> BCD = 0, dado_valido = 0, tecla_nova = 0 throughout.
REQ-025 Priority: enablen = 0, teclado = 10'b1000000001 then 10'b1000001001 -> BCD = 9 both cycles, tecla_nova = 1 only on the first; with enablen = 1 -> BCD = 0, dado_valido = 0.
REQ-026 Stability: STABLE_CYCLES = 3, key 5 held 2 cycles then key 6 held 4 cycles -> dado_valido = 0 until the 3rd sample of key 6, then BCD = 6 with a single tecla_nova pulse.
REQ-027 Release: key 4 valid, then teclado = 0 -> next edge BCD = 0 and dado_valido = 0; pressing key 4 again gives a new tecla_nova pulse.
REQ-028 Async reset: assert rstn = 0 between clock edges while BCD = 7 -> outputs clear immediately; after release, key 7 held -> valid again after STABLE_CYCLES edges.

Source files
------------

// File: rtl/codificador_priori.sv
// Priority encoder for a 10-key digit keypad with a debounce-style stability filter.
// The highest pressed key index is reported as BCD once it has been sampled
// unchanged for STABLE_CYCLES consecutive clocks. tecla_nova pulses for one
// cycle whenever a new code is accepted.
module codificador_priori #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] teclado,
    input  logic       enablen,
    output logic [3:0] BCD,
    output logic       dado_valido,
    output logic       tecla_nova
);

    localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

    logic [3:0] raw_code;
    logic       present;
    logic [3:0] prev_code;
    logic       prev_present;
    logic [7:0] stab_cnt;
    logic [7:0] stab_cnt_nxt;
    logic       valid_nxt;
    logic       new_nxt;

    // Highest set bit wins; later loop iterations override lower indices.
    always_comb begin
        raw_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (teclado[i]) begin
                raw_code = 4'(i);
            end
        end
    end

    assign present = !enablen && (teclado != 10'd0);

    // Stability counter next value plus acceptance decisions for this edge.
    always_comb begin
        stab_cnt_nxt = 8'd0;
        if (present) begin
            if (prev_present && (raw_code == prev_code)) begin
                stab_cnt_nxt = (stab_cnt == STABLE_TC) ? stab_cnt : stab_cnt + 8'd1;
            end else begin
                stab_cnt_nxt = 8'd1;
            end
        end
        valid_nxt = present && (stab_cnt_nxt == STABLE_TC);
        new_nxt   = valid_nxt && (!dado_valido || (BCD != raw_code));
    end

    // Tracking registers: previous sample and stability count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_code    <= 4'd0;
            prev_present <= 1'b0;
            stab_cnt     <= 8'd0;
        end else begin
            prev_code    <= present ? raw_code : 4'd0;
            prev_present <= present;
            stab_cnt     <= stab_cnt_nxt;
        end
    end

    // Output registers: code is shown only once stable, zero otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            BCD         <= 4'd0;
            dado_valido <= 1'b0;
            tecla_nova  <= 1'b0;
        end else begin
            BCD         <= valid_nxt ? raw_code : 4'd0;
            dado_valido <= valid_nxt;
            tecla_nova  <= new_nxt;
        end
    end

endmodule

// File: tb/tb_codificador_priori.sv
// Directed bench: one instance with STABLE_CYCLES = 1 and one with 3, driven
// from the same keypad/enable/reset inputs.
module tb_codificador_priori;

    logic       clk;
    logic       rstn;
    logic [9:0] teclado;
    logic       enablen;
    logic [3:0] bcd1;
    logic       dv1;
    logic       tn1;
    logic [3:0] bcd3;
    logic       dv3;
    logic       tn3;

    int total;
    int fails;

    codificador_priori #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .teclado(teclado), .enablen(enablen),
        .BCD(bcd1), .dado_valido(dv1), .tecla_nova(tn1)
    );

    codificador_priori #(.STABLE_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn), .teclado(teclado), .enablen(enablen),
        .BCD(bcd3), .dado_valido(dv3), .tecla_nova(tn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] b, input logic v, input logic n);
        chk({tag, " d1.BCD"}, bcd1, b);
        chk({tag, " d1.valid"}, {3'd0, dv1}, {3'd0, v});
        chk({tag, " d1.new"}, {3'd0, tn1}, {3'd0, n});
    endtask

    task automatic chk3(input string tag, input logic [3:0] b, input logic v, input logic n);
        chk({tag, " d3.BCD"}, bcd3, b);
        chk({tag, " d3.valid"}, {3'd0, dv3}, {3'd0, v});
        chk({tag, " d3.new"}, {3'd0, tn3}, {3'd0, n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        fails   = 0;
        rstn    = 1'b0;
        teclado = 10'd0;
        enablen = 1'b1;

        #2;
        chk1("reset", 4'd0, 1'b0, 1'b0);
        chk3("reset", 4'd0, 1'b0, 1'b0);
        step();
        rstn = 1'b1;
        step();

        // Walk one-hot 9..0, enabled
        enablen = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            teclado = 10'd1 << i;
            step();
            chk1($sformatf("walk%0d", i), 4'(i), 1'b1, 1'b1);
            chk3($sformatf("walk%0d", i), 4'd0, 1'b0, 1'b0);
        end
        teclado = 10'd0;
        step();
        chk1("walk_release", 4'd0, 1'b0, 1'b0);

        // Same walk, disabled
        enablen = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            teclado = 10'd1 << i;
            step();
            chk1($sformatf("dis%0d", i), 4'd0, 1'b0, 1'b0);
        end

        // Priority: lower keys do not disturb the code
        enablen = 1'b0;
        teclado = 10'b1000000001;
        step();
        chk1("prio_a", 4'd9, 1'b1, 1'b1);
        teclado = 10'b1000001001;
        step();
        chk1("prio_b", 4'd9, 1'b1, 1'b0);
        enablen = 1'b1;
        step();
        chk1("prio_dis", 4'd0, 1'b0, 1'b0);

        // Stability with STABLE_CYCLES = 3
        enablen = 1'b0;
        teclado = 10'd0;
        step();
        teclado = 10'd1 << 5;
        step();
        chk3("stab5_1", 4'd0, 1'b0, 1'b0);
        step();
        chk3("stab5_2", 4'd0, 1'b0, 1'b0);
        teclado = 10'd1 << 6;
        step();
        chk3("stab6_1", 4'd0, 1'b0, 1'b0);
        step();
        chk3("stab6_2", 4'd0, 1'b0, 1'b0);
        step();
        chk3("stab6_3", 4'd6, 1'b1, 1'b1);
        step();
        chk3("stab6_4", 4'd6, 1'b1, 1'b0);

        // Release and re-press key 4
        teclado = 10'd1 << 4;
        step();
        chk1("rel_press", 4'd4, 1'b1, 1'b1);
        teclado = 10'd0;
        step();
        chk1("rel_zero", 4'd0, 1'b0, 1'b0);
        teclado = 10'd1 << 4;
        step();
        chk1("rel_again", 4'd4, 1'b1, 1'b1);

        // Asynchronous reset between edges while key 7 is shown
        teclado = 10'd1 << 7;
        step();
        chk1("pre_rst", 4'd7, 1'b1, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        chk1("async_rst", 4'd0, 1'b0, 1'b0);
        chk3("async_rst", 4'd0, 1'b0, 1'b0);
        #2;
        rstn = 1'b1;
        step();
        chk1("post_rst_1", 4'd7, 1'b1, 1'b1);
        chk3("post_rst_1", 4'd0, 1'b0, 1'b0);
        step();
        chk3("post_rst_2", 4'd0, 1'b0, 1'b0);
        step();
        chk3("post_rst_3", 4'd7, 1'b1, 1'b1);
        chk1("post_rst_3", 4'd7, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
